modn_updown_counter: RTL

- Parametrised modulo-N up/down counter; the generalised successor to the fixed 0..59 seconds/minutes counter in the clock datapath.
- Adds configurable modulus, width and reset value, a wrap or saturate mode, a synchronous parallel load with range checking, and boundary flags.
- Instances chain by wiring o_carryup/o_borrowdown of a lower digit into i_up/i_down of the next (seconds -> minutes -> hours).

---
 rtl/modn_updown_counter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with wrap or saturate mode, range-checked parallel load
// and same-cycle carry/borrow outputs for zero-latency digit chaining.
module modn_updown_counter #(
    parameter int MODULUS     = 60,
    parameter int WIDTH       = 6,
    parameter int RESET_VALUE = 0,
    parameter int SATURATE    = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carryup,
    output logic             o_borrowdown,
    output logic             o_at_max,
    output logic             o_at_min,
    output logic             o_load_err
);

    // MAX_VAL becomes all ones when MODULUS == 2**WIDTH, so the load check never rejects.
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
    localparam logic             SAT_MODE = (SATURATE != 32'sd0);

    typedef enum logic [2:0] {
        OP_HOLD     = 3'd0,
        OP_LOAD     = 3'd1,
        OP_LOAD_REJ = 3'd2,
        OP_CLEAR    = 3'd3,
        OP_UP       = 3'd4,
        OP_DOWN     = 3'd5
    } op_e;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             load_err_q;
    logic             load_err_d;
    logic             at_max_s;
    logic             at_min_s;
    logic             load_ok_s;
    op_e              op_s;

    assign at_max_s  = (count_q == MAX_VAL);
    assign at_min_s  = (count_q == ZERO_VAL);
    assign load_ok_s = (i_load_value <= MAX_VAL);

    // Decode the request inputs into a single operation, load first, then clear, up, down.
    always_comb begin
        op_s = OP_HOLD;
        if (i_load) begin
            if (load_ok_s) begin
                op_s = OP_LOAD;
            end else begin
                op_s = OP_LOAD_REJ;
            end
        end else if (i_up && i_down) begin
            op_s = OP_CLEAR;
        end else if (i_up) begin
            op_s = OP_UP;
        end else if (i_down) begin
            op_s = OP_DOWN;
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Next count and load-error pulse; boundary checks come before the +/-1 so nothing overflows.
    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        case (op_s)
            OP_LOAD: begin
                count_d = i_load_value;
            end
            OP_LOAD_REJ: begin
                load_err_d = 1'b1;
            end
            OP_CLEAR: begin
                count_d = ZERO_VAL;
            end
            OP_UP: begin
                if (!at_max_s) begin
                    count_d = count_q + ONE_VAL;
                end else if (SAT_MODE) begin
                    count_d = count_q;
                end else begin
                    count_d = ZERO_VAL;
                end
            end
            OP_DOWN: begin
                if (!at_min_s) begin
                    count_d = count_q - ONE_VAL;
                end else if (SAT_MODE) begin
                    count_d = count_q;
                end else begin
                    count_d = MAX_VAL;
                end
            end
            OP_HOLD: begin
                count_d = count_q;
            end
            default: begin
                count_d    = count_q;
                load_err_d = 1'b0;
            end
        endcase
    end

    // State register; synchronous reset overrides every request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q    <= RST_VAL;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    // Carry/borrow stay combinational so the next digit steps on the same edge as this one wraps.
    assign o_carryup    = i_up & ~i_down & ~i_load & ~i_rst & at_max_s;
    assign o_borrowdown = i_down & ~i_up & ~i_load & ~i_rst & at_min_s;
    assign o_at_max     = at_max_s;
    assign o_at_min     = at_min_s;
    assign o_count      = count_q;
    assign o_load_err   = load_err_q;

endmodule
